// File: rtl/dbi_bus_arbiter.sv
// Round-robin, burst-locking arbiter that shares one DBI-encoded link between N_REQ requesters.
// Optional saturating transfer/inversion counters when DBI_ARB_STATS_EN is defined.
module dbi_bus_arbiter #(
    parameter int bw        = 128,
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dbi_en,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*bw-1:0]   req_data,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  bus_valid,
    output logic [bw:0]           bus_data,
    input  logic                  bus_ready
`ifdef DBI_ARB_STATS_EN
    ,
    output logic [31:0]           stat_words,
    output logic [31:0]           stat_inv
`endif
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam int TW = $clog2(bw + 1);

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [PW-1:0]   r_rr_ptr;
    logic [PW-1:0]   w_rr_next;
    logic [PW-1:0]   r_owner;
    logic [PW-1:0]   w_owner_next;
    logic [CW-1:0]   r_burst_cnt;
    logic [CW-1:0]   w_burst_next;
    logic [CW-1:0]   w_burst_inc;
    logic            r_bus_valid;
    logic [bw:0]     r_bus_data;
    logic [bw-1:0]   r_prev_word;

    logic            w_can_load;
    logic            w_xfer;
    logic [PW-1:0]   w_grant;
    logic            w_grant_vld;
    logic [PW-1:0]   w_idle_grant;
    logic [PW-1:0]   w_scan_idx [N_REQ];
    logic [bw-1:0]   w_req_word [N_REQ];
    logic [N_REQ-1:0] w_req_ready;
    logic [bw-1:0]   w_sel_data;
    logic [bw-1:0]   w_diff;
    logic [TW-1:0]   w_pop;
    logic            w_inv;
    logic [bw-1:0]   w_drv_word;

    function automatic logic [PW-1:0] f_next_idx(input logic [PW-1:0] idx);
        if (idx == PW'(N_REQ - 1)) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            logic [PW:0] w_sum;
            // Position gi of the round-robin scan, starting at r_rr_ptr and wrapping at N_REQ.
            assign w_sum           = {1'b0, r_rr_ptr} + (PW + 1)'(gi);
            assign w_scan_idx[gi]  = (w_sum >= (PW + 1)'(N_REQ)) ? PW'(w_sum - (PW + 1)'(N_REQ))
                                                                   : PW'(w_sum);
            assign w_req_word[gi]  = req_data[gi*bw +: bw];
            assign w_req_ready[gi] = w_grant_vld & w_can_load & (w_grant == PW'(gi));
        end
    endgenerate

    // Lowest scan position wins, so iterate from the far end down.
    always_comb begin
        w_idle_grant = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid[w_scan_idx[k]]) begin
                w_idle_grant = w_scan_idx[k];
            end
        end
    end

    always_comb begin
        w_grant     = w_idle_grant;
        w_grant_vld = |req_valid;
        if (r_state == OWN) begin
            w_grant     = r_owner;
            w_grant_vld = req_valid[r_owner];
        end
    end

    assign w_can_load  = ~r_bus_valid | bus_ready;
    assign req_ready   = w_req_ready;
    assign w_xfer      = |(req_valid & w_req_ready);
    assign w_burst_inc = r_burst_cnt + CW'(1);

    always_comb begin
        w_state_next = r_state;
        w_rr_next    = r_rr_ptr;
        w_owner_next = r_owner;
        w_burst_next = r_burst_cnt;
        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    if (MAX_BURST > 1) begin
                        w_state_next = OWN;
                        w_owner_next = w_idle_grant;
                        w_burst_next = CW'(1);
                    end else begin
                        w_rr_next = f_next_idx(w_idle_grant);
                    end
                end
            end
            OWN: begin
                if (!req_valid[r_owner]) begin
                    w_state_next = IDLE;
                    w_rr_next    = f_next_idx(r_owner);
                    w_burst_next = '0;
                end else if (w_xfer) begin
                    w_burst_next = w_burst_inc;
                    if (w_burst_inc == CW'(MAX_BURST)) begin
                        w_state_next = IDLE;
                        w_rr_next    = f_next_idx(r_owner);
                        w_burst_next = '0;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Invert only when strictly more than half the lanes would toggle; a tie is sent as-is.
    always_comb begin
        w_sel_data = w_req_word[w_grant];
        w_diff     = w_sel_data ^ r_prev_word;
        w_pop      = '0;
        for (int b = 0; b < bw; b++) begin
            w_pop = w_pop + TW'(w_diff[b]);
        end
        w_inv      = dbi_en & (w_pop > TW'(bw / 2));
        w_drv_word = w_inv ? ~w_sel_data : w_sel_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_burst_cnt <= '0;
            r_bus_valid <= 1'b0;
            r_bus_data  <= '0;
            r_prev_word <= '0;
        end else begin
            r_state     <= w_state_next;
            r_rr_ptr    <= w_rr_next;
            r_owner     <= w_owner_next;
            r_burst_cnt <= w_burst_next;
            if (w_xfer) begin
                r_bus_valid <= 1'b1;
                r_bus_data  <= {w_inv, w_drv_word};
                r_prev_word <= w_drv_word;
            end else if (bus_ready) begin
                r_bus_valid <= 1'b0;
            end
        end
    end

    assign bus_valid = r_bus_valid;
    assign bus_data  = r_bus_data;

`ifdef DBI_ARB_STATS_EN
    logic [31:0] r_stat_words;
    logic [31:0] r_stat_inv;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_words <= '0;
            r_stat_inv   <= '0;
        end else if (w_xfer) begin
            if (r_stat_words != '1) begin
                r_stat_words <= r_stat_words + 32'd1;
            end
            if (w_inv && (r_stat_inv != '1)) begin
                r_stat_inv <= r_stat_inv + 32'd1;
            end
        end
    end

    assign stat_words = r_stat_words;
    assign stat_inv   = r_stat_inv;
`endif

endmodule
